// File: rtl/debouncer_pkg.sv
// rtl/debouncer_pkg.sv - shared constants, width helpers and parameter checks for debouncer_bank
package debouncer_pkg;

    localparam int DEF_N_CH          = 4;
    localparam int DEF_DB_CYCLES     = 2000000;
    localparam int DEF_HOLD_CYCLES   = 50000000;
    localparam int DEF_REPEAT_CYCLES = 10000000;
    localparam int DEF_ACTIVE_LOW    = 1;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        longint lim;
        int     w;
        lim = 2;
        w   = 1;
        while (lim < longint'(value)) begin
            lim = lim * 2;
            w   = w + 1;
        end
        return w;
    endfunction

    // Debounce counter runs 0..DB_CYCLES-1.
    function automatic int db_w(input int db_cycles);
        return clog2(db_cycles);
    endfunction

    // Hold counter saturates at HOLD_CYCLES itself, so it needs one extra value.
    function automatic int hold_w(input int hold_cycles);
        return clog2(hold_cycles + 1);
    endfunction

    // Repeat counter runs 0..REPEAT_CYCLES-1.
    function automatic int rpt_w(input int repeat_cycles);
        return clog2(repeat_cycles);
    endfunction

    function automatic bit params_ok(input int db_cycles, input int hold_cycles,
                                     input int repeat_cycles);
        return (db_cycles >= 2) && (hold_cycles >= 1) && (repeat_cycles >= 1);
    endfunction

endpackage

// File: rtl/debouncer_bank_if.sv
// rtl/debouncer_bank_if.sv - button pins and conditioned button outputs of debouncer_bank
interface debouncer_bank_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] button;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] r_edge;
    logic [N_CH-1:0] f_edge;
    logic [N_CH-1:0] long_press;
    logic [N_CH-1:0] rpt;

    // Board / consumer side: drives the pins, observes the conditioned outputs.
    modport master (output button, input level, r_edge, f_edge, long_press, rpt);
    // Conditioner side.
    modport slave  (input button, output level, r_edge, f_edge, long_press, rpt);
endinterface

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one button channel: sync, debounce, edges, long press, optional repeat (DEBOUNCER_BANK_REPEAT_EN)
import debouncer_pkg::*;

module debounce_ch #(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level,
    output logic r_edge,
    output logic f_edge,
    output logic long_press,
    output logic rpt
);
    localparam int   DB_W   = db_w(DB_CYCLES);
    localparam int   HOLD_W = hold_w(HOLD_CYCLES);
    localparam logic ACT    = (ACTIVE_LOW != 0);

    if (!params_ok(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) begin : g_bad_params
        $error("debounce_ch: DB_CYCLES must be >= 2, HOLD_CYCLES and REPEAT_CYCLES >= 1");
    end

    logic              s0, s1;
    logic              sample;
    logic              acc;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              rise, fall, hold_hit;

    // The sync FFs keep the raw pin, so resetting them to the raw idle level avoids a false press.
    assign sample   = s1 ^ ACT;
    // acc is the accepted level one cycle ahead of the registered level output.
    assign rise     = acc & ~level;
    assign fall     = ~acc & level;
    assign hold_hit = acc && !rise && (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= ACT;
            s1 <= ACT;
        end else begin
            s0 <= button;
            s1 <= s0;
        end
    end

    // Accept a new level only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= 1'b0;
            db_cnt <= '0;
        end else if (sample == acc) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            acc    <= sample;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Registered level and one-cycle event pulses, all aligned to the level change.
    always_ff @(posedge clk) begin
        if (rst) begin
            level      <= 1'b0;
            r_edge     <= 1'b0;
            f_edge     <= 1'b0;
            long_press <= 1'b0;
        end else begin
            level      <= acc;
            r_edge     <= rise;
            f_edge     <= fall;
            long_press <= hold_hit;
        end
    end

    // Saturating hold timer; restarts on every new press and clears while released.
    always_ff @(posedge clk) begin
        if (rst || !acc || rise) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_W'(HOLD_CYCLES)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

`ifdef DEBOUNCER_BANK_REPEAT_EN
    localparam int RPT_W = rpt_w(REPEAT_CYCLES);

    logic             rpt_on;
    logic [RPT_W-1:0] rpt_cnt;

    // Periodic repeat after a long press; a release stops it before the f_edge cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_on  <= 1'b0;
            rpt_cnt <= '0;
            rpt     <= 1'b0;
        end else begin
            rpt <= 1'b0;
            if (!acc) begin
                rpt_on  <= 1'b0;
                rpt_cnt <= '0;
            end else if (hold_hit) begin
                rpt_on  <= 1'b1;
                rpt_cnt <= '0;
            end else if (rpt_on) begin
                if (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1)) begin
                    rpt_cnt <= '0;
                    rpt     <= 1'b1;
                end else begin
                    rpt_cnt <= rpt_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/debouncer_bank.sv
// rtl/debouncer_bank.sv - N independent push-button conditioners (auto-repeat via DEBOUNCER_BANK_REPEAT_EN)
import debouncer_pkg::*;

module debouncer_bank #(
    parameter int N_CH          = DEF_N_CH,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
    input  logic             clk,
    input  logic             rst,
    debouncer_bank_if.slave  bus
);

    // One fully independent conditioner per button.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DB_CYCLES     (DB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .button     (bus.button[i]),
            .level      (bus.level[i]),
            .r_edge     (bus.r_edge[i]),
            .f_edge     (bus.f_edge[i]),
            .long_press (bus.long_press[i]),
            .rpt        (bus.rpt[i])
        );
    end

endmodule

// File: tb/tb_debouncer_bank.sv
// tb/tb_debouncer_bank.sv - scoreboard bench for debouncer_bank against a sample-window reference model
module tb_debouncer_bank;
    localparam int N_CH = 2;
    localparam int DB   = 8;
    localparam int HOLD = 32;
    localparam int RPT  = 10;
    localparam int AL   = 1;
    localparam int MAXC = 5000;
`ifdef DEBOUNCER_BANK_REPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [N_CH-1:0] level;
        logic [N_CH-1:0] r;
        logic [N_CH-1:0] f;
        logic [N_CH-1:0] lp;
        logic [N_CH-1:0] rp;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] press = '0;

    debouncer_bank_if #(.N_CH(N_CH)) bus();
    assign bus.button = (AL != 0) ? ~press : press;

    debouncer_bank #(
        .N_CH(N_CH), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(RPT), .ACTIVE_LOW(AL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    // Reference model: a level is accepted once DB consecutive synchronised samples
    // disagree with it; outputs appear DB+2 clocks after the first such sample.
    bit hist [N_CH][MAXC];
    bit acc_m [N_CH];
    bit prev_lvl [N_CH];
    int rise_t [N_CH];

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        e = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            bit p, lvl, stable;
            int d;
            p = bus.button[ch] ^ AL[0];
            if (rst) begin
                hist[ch][cyc]     = 1'b0;
                hist[ch][cyc - 1] = 1'b0;
                acc_m[ch]    = 1'b0;
                prev_lvl[ch] = 1'b0;
                rise_t[ch]   = -1;
            end else begin
                hist[ch][cyc] = p;
                lvl = acc_m[ch];
                e.level[ch] = lvl;
                e.r[ch] = lvl & ~prev_lvl[ch];
                e.f[ch] = ~lvl & prev_lvl[ch];
                if (e.r[ch]) rise_t[ch] = cyc;
                if (!lvl) rise_t[ch] = -1;
                d = cyc - rise_t[ch] - HOLD;
                e.lp[ch] = (rise_t[ch] >= 0) && (d == 0);
                e.rp[ch] = RPT_ON && (rise_t[ch] >= 0) && (d > 0) && (d % RPT == 0);
                if (cyc - DB - 1 >= 0) begin
                    stable = 1'b1;
                    for (int k = cyc - DB - 1; k <= cyc - 2; k++)
                        if (hist[ch][k] == acc_m[ch]) stable = 1'b0;
                    if (stable) acc_m[ch] = ~acc_m[ch];
                end
                prev_lvl[ch] = lvl;
            end
        end
        sb.push_back(e);
    end

    int r_cnt [N_CH];
    int f_cnt [N_CH];
    int lp_cnt [N_CH];
    int rp_cnt [N_CH];
    int last_r [N_CH];
    int last_f [N_CH];
    int last_lp [N_CH];

    // Monitor: every cycle the DUT presents a full output set; pop and compare.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_entries", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("level",      int'(bus.level),      int'(e.level));
            chk("r_edge",     int'(bus.r_edge),     int'(e.r));
            chk("f_edge",     int'(bus.f_edge),     int'(e.f));
            chk("long_press", int'(bus.long_press), int'(e.lp));
            chk("repeat",     int'(bus.rpt),        int'(e.rp));
        end
        for (int ch = 0; ch < N_CH; ch++) begin
            if (bus.r_edge[ch])     begin r_cnt[ch]++;  last_r[ch]  = cyc; end
            if (bus.f_edge[ch])     begin f_cnt[ch]++;  last_f[ch]  = cyc; end
            if (bus.long_press[ch]) begin lp_cnt[ch]++; last_lp[ch] = cyc; end
            if (bus.rpt[ch])        rp_cnt[ch]++;
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int dur [N_CH];
        int r0, f0, lp0;
        for (int ch = 0; ch < N_CH; ch++) begin
            r_cnt[ch] = 0; f_cnt[ch] = 0; lp_cnt[ch] = 0; rp_cnt[ch] = 0;
            last_r[ch] = -1; last_f[ch] = -1; last_lp[ch] = -1; dur[ch] = 0;
            rise_t[ch] = -1;
        end
        goto(3);
        rst = 1'b0;

        // Clean press sampled at cycle 100.
        goto(99);  press[0] = 1'b1;
        goto(112);
        chk("clean_r_cycle", last_r[0], 110);
        chk("clean_r_count", r_cnt[0], 1);
        chk("clean_ch1_quiet", r_cnt[1], 0);

        // Long press with repeats, released at r_edge+70.
        goto(175);
        chk("long_cycle", last_lp[0], 142);
        chk("long_count", lp_cnt[0], 1);
        goto(179); press[0] = 1'b0;
        goto(200);
        chk("long_f_cycle", last_f[0], 190);
        chk("repeat_count", rp_cnt[0], RPT_ON ? 4 : 0);

        // Short press released at r_edge+20.
        goto(249); press[0] = 1'b1;
        goto(279); press[0] = 1'b0;
        goto(320);
        chk("short_r_cycle", last_r[0], 260);
        chk("short_f_cycle", last_f[0], 290);
        chk("short_no_long", lp_cnt[0], 1);

        // Bounce every 3 cycles, then settle pressed at 430.
        r0 = r_cnt[0]; f0 = f_cnt[0];
        for (int k = 0; k < 10; k++) begin
            goto(399 + 3 * k);
            press[0] = ~press[0];
        end
        goto(429); press[0] = 1'b1;
        goto(460);
        chk("bounce_r_count", r_cnt[0] - r0, 1);
        chk("bounce_r_cycle", last_r[0], 440);
        chk("bounce_no_f", f_cnt[0] - f0, 0);

        // One-cycle reset while pressed.
        lp0 = lp_cnt[0];
        goto(469); rst = 1'b1;
        goto(470); rst = 1'b0;
        goto(500);
        chk("rst_no_f", f_cnt[0] - f0, 0);
        chk("rst_r_cycle", last_r[0], 481);
        chk("rst_no_long", lp_cnt[0] - lp0, 0);
        goto(519); press[0] = 1'b0;

        // Both channels pressed together, then a 2-cycle glitch on channel 1.
        goto(599); press = 2'b11;
        goto(620);
        chk("simul_r_ch0", last_r[0], 610);
        chk("simul_r_ch1", last_r[1], 610);
        goto(649); press[1] = 1'b0;
        goto(651); press[1] = 1'b1;
        goto(690);
        chk("glitch_no_f_ch1", f_cnt[1], 0);
        chk("glitch_ch0_level", int'(bus.level[0]), 1);
        goto(699); press = 2'b00;

        // Randomised presses, bounces and occasional resets.
        for (int c = 800; c < 3800; c++) begin
            goto(c);
            for (int ch = 0; ch < N_CH; ch++) begin
                if (dur[ch] == 0) begin
                    press[ch] = ~press[ch];
                    dur[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 90))
                                                          : int'($urandom_range(1, 12));
                end else begin
                    dur[ch]--;
                end
            end
            rst = ($urandom_range(0, 399) == 0);
        end
        rst = 1'b0;
        goto(3830);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
